// File: rtl/adder_stage2_2_sched.sv
// adder_stage2_2_sched: sequencer for the gated 3-input adder of conv layer 2,
// addition stage 2. Groups the stage-1 partial-sum stream into operand triples,
// pulses add_en once per triple, and hands each result downstream.
// Ports: clk/reset (async, active-high); start, busy, frame_done, err;
// in_valid/in_ready/in_data (sample stream); add_en, add_op1..3, add_sum,
// add_done (adder side); out_valid/out_ready/out_data (result stream).
module adder_stage2_2_sched #(
    parameter int DATA_W  = 12,
    parameter int SUM_W   = 14,
    parameter int NUM_OUT = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              add_en,
    output logic [DATA_W-1:0] add_op1,
    output logic [DATA_W-1:0] add_op2,
    output logic [DATA_W-1:0] add_op3,
    input  logic [SUM_W-1:0]  add_sum,
    input  logic              add_done,
    output logic              out_valid,
    output logic [SUM_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam int CW = $clog2(NUM_OUT + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_OUT);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_FIRE    = 2'd2;
    localparam logic [1:0] S_WAIT    = 2'd3;

    logic [1:0]    state;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          hs;
    logic          out_free;
    logic          fire;
    logic          last_hs;

    assign in_ready = (state == S_COLLECT) && (idx != 2'd3);
    assign accept   = in_valid && in_ready;
    assign hs       = out_valid && out_ready;
    assign out_free = !out_valid || out_ready;

    // Fire on the same edge the third sample lands, so a triple costs
    // 3 accept cycles + FIRE + WAIT when nothing stalls.
    assign fire = (state == S_COLLECT) && out_free &&
                  ((idx == 2'd3) || ((idx == 2'd2) && accept));

    // cnt reaches NUM_OUT only after the last result is captured.
    assign last_hs = hs && busy && (cnt == LAST);

    // Operands move only on accepted samples, keeping adder inputs quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            add_op1 <= '0;
            add_op2 <= '0;
            add_op3 <= '0;
        end else if (accept) begin
            case (idx)
                2'd0:    add_op1 <= in_data;
                2'd1:    add_op2 <= in_data;
                2'd2:    add_op3 <= in_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            cnt        <= '0;
            add_en     <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            add_en     <= fire;
            frame_done <= last_hs;
            if (last_hs) begin
                busy <= 1'b0;
            end
            if (hs) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (start && !busy) begin
                        state <= S_COLLECT;
                        busy  <= 1'b1;
                        idx   <= 2'd0;
                        cnt   <= '0;
                    end
                end
                S_COLLECT: begin
                    if (fire) begin
                        state <= S_FIRE;
                        idx   <= 2'd0;
                    end else if (accept) begin
                        idx <= idx + 2'd1;
                    end
                end
                S_FIRE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Output register is guaranteed free here: FIRE was
                    // only entered with out_valid clear or draining.
                    out_data  <= add_sum;
                    out_valid <= 1'b1;
                    cnt       <= cnt + CW'(1);
                    if (!add_done) begin
                        err <= 1'b1;
                    end
                    if (cnt == LAST - CW'(1)) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_COLLECT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_stage2_2_sched.sv
// tb_adder_stage2_2_sched: directed + random bench for adder_stage2_2_sched.
// Expected results come from a sample-triple sum model and cycle arithmetic.
module tb_adder_stage2_2_sched;

    localparam int DATA_W  = 12;
    localparam int SUM_W   = 14;
    localparam int NUM_OUT = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              add_en;
    logic [DATA_W-1:0] add_op1;
    logic [DATA_W-1:0] add_op2;
    logic [DATA_W-1:0] add_op3;
    logic [SUM_W-1:0]  add_sum;
    logic              add_done;
    logic              out_valid;
    logic [SUM_W-1:0]  out_data;
    logic              out_ready;
    logic              busy;
    logic              frame_done;
    logic              err;

    adder_stage2_2_sched #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W),
        .NUM_OUT(NUM_OUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .add_en    (add_en),
        .add_op1   (add_op1),
        .add_op2   (add_op2),
        .add_op3   (add_op3),
        .add_sum   (add_sum),
        .add_done  (add_done),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_done(frame_done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in gated adder: result and done flag one cycle after add_en.
    logic [SUM_W-1:0] sum_r;
    logic             done_r;
    logic             kill;
    always @(posedge clk) begin
        done_r <= add_en;
        if (add_en) begin
            sum_r <= SUM_W'($signed(add_op1)) + SUM_W'($signed(add_op2))
                   + SUM_W'($signed(add_op3));
        end
    end
    assign add_sum  = sum_r;
    assign add_done = done_r & ~kill;

    int               cyc = 0;
    int               en_cnt = 0;
    int               fd_cnt = 0;
    logic [SUM_W-1:0] got_q[$];
    int               got_t[$];
    logic [SUM_W-1:0] exp_q[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset && out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_t.push_back(cyc);
        end
        if (!reset && add_en) en_cnt = en_cnt + 1;
        if (!reset && frame_done) fd_cnt = fd_cnt + 1;
    end

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] sa, sb, sc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, output int acc);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 60) begin
            tick();
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        tick();
        acc = cyc;
        in_valid = 1'b0;
    endtask

    // Model: result is the sign-extended sum of the triple, no overflow.
    task automatic send_triple(input logic [DATA_W-1:0] a,
                               input logic [DATA_W-1:0] b,
                               input logic [DATA_W-1:0] c,
                               output int acc3);
        int s;
        int t;
        s = int'($signed(a)) + int'($signed(b)) + int'($signed(c));
        exp_q.push_back(SUM_W'(s));
        sa = a;
        sb = b;
        sc = c;
        send(a, t);
        send(b, t);
        send(c, acc3);
    endtask

    task automatic rnd_triple(output int acc3);
        send_triple(12'($urandom), 12'($urandom), 12'($urandom), acc3);
    endtask

    task automatic wait_results(input int target);
        int n;
        n = 0;
        while (got_q.size() < target && n < 100) begin
            tick();
            n++;
        end
        chk("result_timeout", 32'(got_q.size() >= target), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_add_en"}, 32'(add_en), 32'd0);
        chk({tag, "_ops"}, 32'({add_op1, add_op2, add_op3}), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic check_frame(input int g0, input int e0, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("result%0d", i), 32'(got_q[g0+i]), 32'(exp_q[e0+i]));
        end
    endtask

    initial begin
        int a1, t, g0, e0, en0, fd0;
        logic [SUM_W-1:0] d0;

        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        kill = 1'b0;
        repeat (2) tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // Frame 1: continuous feed, directed + random triples.
        g0 = got_q.size();
        e0 = exp_q.size();
        en0 = en_cnt;
        fd0 = fd_cnt;
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("collect_in_ready", 32'(in_ready), 32'd1);
        send_triple(12'h7FF, 12'h7FF, 12'h7FF, a1);
        chk("fire_add_en", 32'(add_en), 32'd1);
        chk("fire_in_ready", 32'(in_ready), 32'd0);
        send_triple(12'h800, 12'h800, 12'h800, t);
        send_triple(12'h005, 12'hFFD, 12'h00A, t);
        chk("op_order", 32'({add_op1, add_op2, add_op3}), 32'h005FFD00A);
        rnd_triple(t);
        wait_results(g0 + 4);
        chk("f1_frame_done", 32'(frame_done), 32'd1);
        chk("f1_busy_low", 32'(busy), 32'd0);
        tick();
        chk("f1_frame_done_pulse", 32'(frame_done), 32'd0);
        chk("f1_in_ready_after", 32'(in_ready), 32'd0);
        check_frame(g0, e0, 4);
        chk("r0_7ff", 32'(got_q[g0]), 32'h17FD);
        chk("r1_800", 32'(got_q[g0+1]), 32'h2800);
        chk("r2_mix", 32'(got_q[g0+2]), 32'h000C);
        chk("latency", 32'(got_t[g0]), 32'(a1 + 3));
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("spacing%0d", i),
                32'(got_t[g0+i] - got_t[g0+i-1]), 32'd5);
        end
        chk("f1_en_count", 32'(en_cnt - en0), 32'd4);
        chk("f1_fd_count", 32'(fd_cnt - fd0), 32'd1);

        // Frame 2: downstream stall after the first result.
        g0 = got_q.size();
        e0 = exp_q.size();
        fd0 = fd_cnt;
        pulse_start();
        rnd_triple(t);
        out_ready = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        d0 = out_data;
        chk("stall_first", 32'(d0), 32'(exp_q[e0]));
        rnd_triple(t);
        en0 = en_cnt;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_data", 32'(out_data), 32'(d0));
        end
        chk("stall_no_en", 32'(en_cnt - en0), 32'd0);
        chk("stall_ops", 32'({add_op1, add_op2, add_op3}), 32'({sa, sb, sc}));
        out_ready = 1'b1;
        tick();
        chk("release_fire", 32'(add_en), 32'd1);
        rnd_triple(t);
        rnd_triple(t);
        wait_results(g0 + 4);
        chk("f2_frame_done", 32'(frame_done), 32'd1);
        tick();
        check_frame(g0, e0, 4);
        chk("f2_fd_count", 32'(fd_cnt - fd0), 32'd1);

        // Frame 3: missing add_done, then reset during WAIT.
        g0 = got_q.size();
        e0 = exp_q.size();
        pulse_start();
        kill = 1'b1;
        rnd_triple(t);
        tick();
        tick();
        kill = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        chk("err_out_valid", 32'(out_valid), 32'd1);
        chk("err_out_data", 32'(out_data), 32'(exp_q[e0]));
        tick();
        tick();
        chk("err_sticky", 32'(err), 32'd1);
        rnd_triple(t);
        tick();
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Frame 4: count restarts from zero after reset.
        g0 = got_q.size();
        e0 = exp_q.size();
        fd0 = fd_cnt;
        pulse_start();
        for (int i = 0; i < 4; i++) rnd_triple(t);
        wait_results(g0 + 4);
        chk("f4_frame_done", 32'(frame_done), 32'd1);
        chk("f4_busy_low", 32'(busy), 32'd0);
        chk("f4_err_clear", 32'(err), 32'd0);
        tick();
        check_frame(g0, e0, 4);
        chk("f4_fd_count", 32'(fd_cnt - fd0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
